// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master among NUM_REQ requesters.
// Optional watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 24,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          Clk_I,
  input  logic                          RstP_I,
  input  logic [NUM_REQ-1:0]            Req_I,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] WrData_I,
  output logic [NUM_REQ-1:0]            Ack_O,
  output logic [DATA_WIDTH-1:0]         RdData_O,
  output logic                          Err_O,
  output logic [NUM_REQ-1:0]            Grant_O,
  output logic                          SpiReq_O,
  output logic [DATA_WIDTH-1:0]         SpiData_O,
  input  logic [DATA_WIDTH-1:0]         SpiData_I,
  input  logic                          SpiValid_I,
  input  logic                          SpiBusy_I,
  input  logic                          SpiCs_I,
  output logic [NUM_REQ-1:0]            CsN_O
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_GAP} state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        cur_q, cur_d;
  logic                    spi_req_q, spi_req_d;
  logic [DATA_WIDTH-1:0]   spi_data_q, spi_data_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic                    pick_valid_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic                    to_hit_s;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  assign to_hit_s = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts only while a transfer is outstanding; flags forced completion.
  always_comb begin
    to_cnt_d = '0;
    err_d    = 1'b0;
    if (state_q == S_REQ || state_q == S_WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_hit_s && !(state_q == S_WAIT && SpiValid_I)) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk_I or posedge RstP_I) begin
    if (RstP_I) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign Err_O = err_q;
`else
  assign to_hit_s = 1'b0;
  assign Err_O    = 1'b0;
`endif

  // First requesting index at or after last+1, wrapping.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_valid_s && Req_I[(int'(last_q) + i) % NUM_REQ]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = IDX_W'((int'(last_q) + i) % NUM_REQ);
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Transaction sequencer next-state and output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    last_d     = last_q;
    cur_d      = cur_q;
    spi_req_d  = spi_req_q;
    spi_data_d = spi_data_q;
    rd_data_d  = rd_data_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          cur_d      = pick_idx_s;
          spi_data_d = WrData_I[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
          spi_req_d  = 1'b1;
          state_d    = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (to_hit_s) begin
          spi_req_d = 1'b0;
          ack_d     = grant_q;
          rd_data_d = '0;
          state_d   = S_DONE;
        end else if (SpiBusy_I) begin
          spi_req_d = 1'b0;
          state_d   = S_WAIT;
        end else begin
          spi_req_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (SpiValid_I) begin
          ack_d     = grant_q;
          rd_data_d = SpiData_I;
          state_d   = S_DONE;
        end else if (to_hit_s) begin
          ack_d     = grant_q;
          rd_data_d = '0;
          state_d   = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        last_d    = cur_q;
        grant_d   = '0;
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        // The master may still be finishing its frame; never re-arm under it.
        if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else if (!SpiBusy_I) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        grant_d   = '0;
        spi_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clk_I or posedge RstP_I) begin
    if (RstP_I) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      last_q     <= LAST_RST;
      cur_q      <= '0;
      spi_req_q  <= 1'b0;
      spi_data_q <= '0;
      rd_data_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      spi_req_q  <= spi_req_d;
      spi_data_q <= spi_data_d;
      rd_data_q  <= rd_data_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign Grant_O   = grant_q;
  assign Ack_O     = ack_q;
  assign SpiReq_O  = spi_req_q;
  assign SpiData_O = spi_data_q;
  assign RdData_O  = rd_data_q;
  assign CsN_O     = {NUM_REQ{SpiCs_I}} | ~grant_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed self-checking bench for spi_master_arbiter with a simple procedural SPI master model.
module tb_spi_master_arbiter;

  localparam int N   = 4;
  localparam int DW  = 24;
  localparam int GAP = 4;
  localparam int TO  = 64;

  logic            Clk_I = 1'b0;
  logic            RstP_I;
  logic [N-1:0]    Req_I;
  logic [N*DW-1:0] WrData_I;
  logic [N-1:0]    Ack_O;
  logic [DW-1:0]   RdData_O;
  logic            Err_O;
  logic [N-1:0]    Grant_O;
  logic            SpiReq_O;
  logic [DW-1:0]   SpiData_O;
  logic [DW-1:0]   SpiData_I;
  logic            SpiValid_I;
  logic            SpiBusy_I;
  logic            SpiCs_I;
  logic [N-1:0]    CsN_O;

  int checks   = 0;
  int failures = 0;

  int   low_run      = 0;
  int   last_low_run = 0;
  int   rise_cnt     = 0;
  logic prev_req     = 1'b0;

  spi_master_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk_I(Clk_I), .RstP_I(RstP_I), .Req_I(Req_I), .WrData_I(WrData_I),
    .Ack_O(Ack_O), .RdData_O(RdData_O), .Err_O(Err_O), .Grant_O(Grant_O),
    .SpiReq_O(SpiReq_O), .SpiData_O(SpiData_O), .SpiData_I(SpiData_I),
    .SpiValid_I(SpiValid_I), .SpiBusy_I(SpiBusy_I), .SpiCs_I(SpiCs_I), .CsN_O(CsN_O)
  );

  always #5 Clk_I = ~Clk_I;

  // Track rising edges of SpiReq_O and the low time preceding each.
  always @(negedge Clk_I) begin
    if (SpiReq_O && !prev_req) begin
      rise_cnt     <= rise_cnt + 1;
      last_low_run <= low_run;
    end
    low_run  <= SpiReq_O ? 0 : low_run + 1;
    prev_req <= SpiReq_O;
  end

  task automatic do_reset();
    RstP_I = 1'b1; Req_I = '0; SpiValid_I = 1'b0; SpiBusy_I = 1'b0; SpiCs_I = 1'b1;
    SpiData_I = '0;
    repeat (2) @(negedge Clk_I);
    RstP_I = 1'b0;
  endtask

  // One full master transaction; the master answers with word r.
  task automatic xfer(input string tag, input logic [N-1:0] g, input logic [DW-1:0] w,
                      input logic [DW-1:0] r, input int max_wait, input bit drop_mid,
                      input bit reraise);
    bit seen = 1'b0;
    for (int i = 0; i < max_wait && !seen; i++) begin
      @(negedge Clk_I);
      if (SpiReq_O === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL %s_req_wait: SpiReq_O=%b required 1", tag, SpiReq_O); return;
    end
    checks++; if (Grant_O !== g) begin failures++; $display("FAIL %s_grant: got %b required %b", tag, Grant_O, g); end
    checks++; if (SpiData_O !== w) begin failures++; $display("FAIL %s_wdata: got %h required %h", tag, SpiData_O, w); end
    checks++; if (CsN_O !== 4'b1111) begin failures++; $display("FAIL %s_cs_idle: got %b required 1111", tag, CsN_O); end
    SpiBusy_I = 1'b1; SpiCs_I = 1'b0;
    #1;
    checks++; if (CsN_O !== ~g) begin failures++; $display("FAIL %s_cs_active: got %b required %b", tag, CsN_O, ~g); end
    @(negedge Clk_I);
    checks++; if (SpiReq_O !== 1'b0) begin failures++; $display("FAIL %s_req_fall: got %b required 0", tag, SpiReq_O); end
    if (drop_mid) Req_I = Req_I & ~g;
    repeat (2) @(negedge Clk_I);
    checks++; if (Ack_O !== 4'b0000) begin failures++; $display("FAIL %s_early_ack: got %b required 0000", tag, Ack_O); end
    SpiValid_I = 1'b1; SpiData_I = r;
    @(negedge Clk_I);
    checks++; if (Ack_O !== g) begin failures++; $display("FAIL %s_ack: got %b required %b", tag, Ack_O, g); end
    checks++; if (RdData_O !== r) begin failures++; $display("FAIL %s_rdata: got %h required %h", tag, RdData_O, r); end
    checks++; if (SpiData_O !== w) begin failures++; $display("FAIL %s_wdata_hold: got %h required %h", tag, SpiData_O, w); end
    checks++; if (Err_O !== 1'b0) begin failures++; $display("FAIL %s_err: got %b required 0", tag, Err_O); end
    SpiValid_I = 1'b0; SpiData_I = '0; Req_I = Req_I & ~g;
    @(negedge Clk_I);
    checks++; if (Ack_O !== 4'b0000) begin failures++; $display("FAIL %s_ack_pulse: got %b required 0000", tag, Ack_O); end
    checks++; if (Grant_O !== 4'b0000) begin failures++; $display("FAIL %s_grant_clear: got %b required 0000", tag, Grant_O); end
    checks++; if (RdData_O !== r) begin failures++; $display("FAIL %s_rdata_hold: got %h required %h", tag, RdData_O, r); end
    SpiBusy_I = 1'b0; SpiCs_I = 1'b1;
    if (reraise) Req_I = Req_I | g;
  endtask

  task automatic test_reset();
    RstP_I = 1'b1; Req_I = 4'b1111; WrData_I = '1; SpiCs_I = 1'b0;
    SpiBusy_I = 1'b0; SpiValid_I = 1'b0; SpiData_I = '0;
    #1;
    checks++; if (Grant_O !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b required 0000", Grant_O); end
    checks++; if (SpiReq_O !== 1'b0) begin failures++; $display("FAIL reset_spireq: got %b required 0", SpiReq_O); end
    checks++; if (Ack_O !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b required 0000", Ack_O); end
    checks++; if (CsN_O !== 4'b1111) begin failures++; $display("FAIL reset_csn: got %b required 1111", CsN_O); end
    checks++; if (SpiData_O !== 24'h000000 || RdData_O !== 24'h000000 || Err_O !== 1'b0) begin
      failures++; $display("FAIL reset_data: spidata=%h rddata=%h err=%b required 0/0/0", SpiData_O, RdData_O, Err_O);
    end
    repeat (3) @(negedge Clk_I);
    checks++; if (Grant_O !== 4'b0000) begin failures++; $display("FAIL reset_hold_grant: got %b required 0000", Grant_O); end
  endtask

  task automatic test_single();
    do_reset();
    WrData_I = '0; WrData_I[1*DW +: DW] = 24'hA5A5A5;
    Req_I = 4'b0010;
    xfer("single", 4'b0010, 24'hA5A5A5, 24'h123456, 1, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    WrData_I = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    Req_I = 4'b1111;
    xfer("rr0", 4'b0001, 24'h111111, 24'h00AB00, 20, 1'b0, 1'b1);
    xfer("rr1", 4'b0010, 24'h222222, 24'h00AB01, 20, 1'b0, 1'b1);
    xfer("rr2", 4'b0100, 24'h333333, 24'h00AB02, 20, 1'b0, 1'b1);
    xfer("rr3", 4'b1000, 24'h444444, 24'h00AB03, 20, 1'b0, 1'b1);
    xfer("rr4", 4'b0001, 24'h111111, 24'h00AB04, 20, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int rise0;
    do_reset();
    WrData_I = '0; WrData_I[0 +: DW] = 24'h00C0DE; WrData_I[DW +: DW] = 24'hFACE01;
    #1 rise0 = rise_cnt;
    Req_I = 4'b0011;
    xfer("b2b_a", 4'b0001, 24'h00C0DE, 24'h0F0001, 20, 1'b0, 1'b0);
    xfer("b2b_b", 4'b0010, 24'hFACE01, 24'h0F0002, 20, 1'b0, 1'b0);
    #1;
    checks++; if (rise_cnt - rise0 !== 2) begin failures++; $display("FAIL b2b_edges: got %0d required 2", rise_cnt - rise0); end
    checks++; if (last_low_run < GAP) begin failures++; $display("FAIL b2b_gap: low for %0d cycles required >= %0d", last_low_run, GAP); end
  endtask

  task automatic test_dropped();
    bit bad = 1'b0;
    do_reset();
    WrData_I = '0; WrData_I[2*DW +: DW] = 24'h5EED02;
    Req_I = 4'b0100;
    xfer("drop", 4'b0100, 24'h5EED02, 24'hD00D02, 20, 1'b1, 1'b0);
    for (int i = 0; i < GAP + 8; i++) begin
      @(negedge Clk_I);
      if (SpiReq_O !== 1'b0 || Grant_O !== 4'b0000) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL drop_regrant: spireq=%b grant=%b required 0/0000", SpiReq_O, Grant_O); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen = 1'b0;
    bit bad  = 1'b0;
    do_reset();
    WrData_I = {24'h000003, 24'h000002, 24'hBEEF01, 24'h000000};
    Req_I = 4'b0001;
    xfer("rst_pre", 4'b0001, 24'h000000, 24'h3C3C3C, 20, 1'b0, 1'b0);
    Req_I = 4'b0010;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk_I);
      if (SpiReq_O === 1'b1) seen = 1'b1;
    end
    checks++; if (Grant_O !== 4'b0010) begin failures++; $display("FAIL rst_grant1: got %b required 0010", Grant_O); end
    SpiBusy_I = 1'b1; SpiCs_I = 1'b0;
    repeat (2) @(negedge Clk_I);
    Req_I = '0; RstP_I = 1'b1;
    #1;
    checks++; if (Grant_O !== 4'b0000 || SpiReq_O !== 1'b0 || Ack_O !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_ctrl: grant=%b spireq=%b ack=%b required 0000/0/0000", Grant_O, SpiReq_O, Ack_O);
    end
    checks++; if (SpiData_O !== 24'h000000 || RdData_O !== 24'h000000) begin
      failures++; $display("FAIL rst_mid_data: spidata=%h rddata=%h required 0/0", SpiData_O, RdData_O);
    end
    checks++; if (CsN_O !== 4'b1111) begin failures++; $display("FAIL rst_mid_csn: got %b required 1111", CsN_O); end
    @(negedge Clk_I);
    RstP_I = 1'b0; SpiValid_I = 1'b1; SpiData_I = 24'h777777;
    @(negedge Clk_I);
    SpiValid_I = 1'b0; SpiData_I = '0;
    for (int i = 0; i < 3; i++) begin
      if (Ack_O !== 4'b0000) bad = 1'b1;
      @(negedge Clk_I);
    end
    checks++; if (bad) begin failures++; $display("FAIL rst_no_ack: ack=%b required 0000", Ack_O); end
    SpiBusy_I = 1'b0; SpiCs_I = 1'b1;
    Req_I = 4'b1111;
    xfer("rst_post", 4'b0001, 24'h000000, 24'h000042, 20, 1'b0, 1'b0);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen = 1'b0;
    bit bad  = 1'b0;
    do_reset();
    WrData_I = '0; WrData_I[0 +: DW] = 24'h0F0F0F;
    Req_I = 4'b0001;
    xfer("to_pre", 4'b0001, 24'h0F0F0F, 24'h5A5A5A, 20, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk_I);
      if (SpiReq_O === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL to_req_wait: SpiReq_O=%b required 1", SpiReq_O); end
    SpiBusy_I = 1'b1; SpiCs_I = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge Clk_I);
      if (Ack_O !== 4'b0000) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL to_early: ack=%b required 0000", Ack_O); end
    @(negedge Clk_I);
    checks++; if (Ack_O !== 4'b0001 || Err_O !== 1'b1) begin
      failures++; $display("FAIL to_ack: ack=%b err=%b required 0001/1", Ack_O, Err_O);
    end
    checks++; if (RdData_O !== 24'h000000) begin failures++; $display("FAIL to_rdata: got %h required 000000", RdData_O); end
    bad = 1'b0;
    for (int i = 0; i < GAP + 4; i++) begin
      @(negedge Clk_I);
      if (SpiReq_O !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL to_gap_busy: spireq=%b required 0", SpiReq_O); end
    SpiBusy_I = 1'b0; SpiCs_I = 1'b1;
    xfer("to_post", 4'b0001, 24'h0F0F0F, 24'h000077, 10, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_dropped();
    test_reset_mid_wait();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
